// File: rtl/counting_sender_pkg.sv
// Shared constants for the counting subsystem.
// Symbol codes used by sender and detector; sender state encodings.
package counting_sender_pkg;

  typedef logic [1:0] sym_t;

  localparam sym_t SYM_IDLE = 2'd0;
  localparam sym_t SYM_1    = 2'd1;
  localparam sym_t SYM_2    = 2'd2;
  localparam sym_t SYM_3    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND1 = 3'd1,
    ST_SEND2 = 3'd2,
    ST_SEND3 = 3'd3,
    ST_GAP   = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/counting_sender_if.sv
// Request/symbol bundle of the counting sender.
// master: sender side (drives num/valid/busy/done); slave: requester/sink.
interface counting_sender_if #(
  parameter int CNT_W = 4
);
  import counting_sender_pkg::*;

  logic             start;
  logic [CNT_W-1:0] reps;
  logic             gap;
  logic             ready;
  sym_t             num;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    input  start, reps, gap, ready,
    output num, valid, busy, done
  );

  modport slave (
    output start, reps, gap, ready,
    input  num, valid, busy, done
  );

endinterface

// File: rtl/counting_sender.sv
// Emits a programmed number of 1,2,3 patterns on num, with optional gaps.
// Ports: clk, reset (async, active-high), bus (counting_sender_if.master).
module counting_sender
  import counting_sender_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  counting_sender_if.master  bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gap_q, gap_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // zero reps skips straight to the completion pulse
          if (bus.reps != '0) begin
            cnt_d   = bus.reps;
            gap_d   = bus.gap;
            state_d = ST_SEND1;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_SEND1: if (bus.ready) state_d = ST_SEND2;
      ST_SEND2: if (bus.ready) state_d = ST_SEND3;
      ST_SEND3: begin
        if (bus.ready) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1))
            state_d = ST_FIN;
          else if (gap_q)
            state_d = ST_GAP;
          else
            state_d = ST_SEND1;
        end
      end
      ST_GAP:  state_d = ST_SEND1;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.num   = SYM_IDLE;
    bus.valid = 1'b0;
    bus.busy  = (state_q != ST_IDLE);
    bus.done  = (state_q == ST_FIN);
    unique case (1'b1)
      (state_q == ST_SEND1): begin
        bus.num   = SYM_1;
        bus.valid = 1'b1;
      end
      (state_q == ST_SEND2): begin
        bus.num   = SYM_2;
        bus.valid = 1'b1;
      end
      (state_q == ST_SEND3): begin
        bus.num   = SYM_3;
        bus.valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_counting_sender.sv
// Scoreboard bench for counting_sender.
// Expected event stream (symbols, gaps, done) is queued per request.
module tb_counting_sender;

  localparam int CNT_W = 4;
  localparam int EV_DONE = 4;

  logic clk;
  logic reset;
  bit   mon_en;
  int   tests;
  int   fails;
  int   sb[$];

  counting_sender_if #(.CNT_W(CNT_W)) bus ();

  counting_sender #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Expected observable events of one request with a free-running sink:
  // accepted symbols 1,2,3 per pattern, 0 for a gap cycle, then done.
  task automatic push_req(input int r, input bit g);
    for (int p = 0; p < r; p++) begin
      sb.push_back(1);
      sb.push_back(2);
      sb.push_back(3);
      if (g && p < r - 1) sb.push_back(0);
    end
    sb.push_back(EV_DONE);
  endtask

  // Monitor: samples after the driver has set inputs for the next edge.
  always begin
    @(negedge clk);
    #2;
    if (mon_en && !reset) begin
      int ev;
      ev = -1;
      if (!bus.valid && bus.num != 2'd0)
        chk("num_zero_when_invalid", int'(bus.num), 0);
      if ((bus.valid || bus.done) && !bus.busy)
        chk("busy_with_activity", int'(bus.busy), 1);
      if (bus.valid && bus.ready) ev = int'(bus.num);
      else if (bus.done) ev = EV_DONE;
      else if (bus.busy && !bus.valid) ev = 0;
      if (ev >= 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", ev, -1);
        end else begin
          chk("event", ev, sb.pop_front());
        end
      end
    end
  end

  // mode: 0 ready high, 1 random ready, 2 stall two cycles in SEND2
  task automatic run_req(input int r, input bit g, input int mode,
                         input bit spur);
    int cyc;
    int n2;
    int stall;
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      step();
      cyc++;
    end
    if (bus.busy) chk("idle_timeout", 1, 0);
    push_req(r, g);
    bus.start = 1'b1;
    bus.reps  = CNT_W'(r);
    bus.gap   = g;
    bus.ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    step();
    bus.start = 1'b0;
    bus.reps  = CNT_W'($urandom);
    bus.gap   = 1'($urandom);
    if (r == 0)
      chk("first_cycle_zero", {bus.busy, bus.done, bus.valid}, 3'b110);
    else
      chk("first_symbol", {bus.valid, bus.num}, 3'b101);
    n2 = 0;
    stall = 0;
    cyc = 0;
    while (!bus.done && cyc < 500) begin
      if (bus.valid && bus.num == 2'd2) n2++;
      if (mode == 1)
        bus.ready = 1'($urandom_range(0, 1));
      else if (mode == 2 && bus.valid && bus.num == 2'd2 && stall < 2) begin
        bus.ready = 1'b0;
        stall++;
      end else
        bus.ready = 1'b1;
      bus.start = spur && bus.busy;
      bus.reps  = CNT_W'($urandom);
      step();
      cyc++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
    bus.start = spur;
    step();
    bus.start = 1'b0;
    chk("idle_after_done", {bus.busy, bus.valid, bus.done}, 3'b000);
    if (mode == 2) chk("send2_hold_cycles", n2, 3);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    mon_en = 1'b0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.reps = '0;
    bus.gap = 1'b0;
    bus.ready = 1'b1;
    #3;
    chk("reset_outputs",
        {bus.num, bus.valid, bus.busy, bus.done}, 5'b00000);
    step();
    step();
    reset = 1'b0;
    mon_en = 1'b1;
    step();
    chk("post_reset_idle",
        {bus.num, bus.valid, bus.busy, bus.done}, 5'b00000);

    run_req(2, 1'b0, 0, 1'b0);
    run_req(2, 1'b1, 0, 1'b0);
    run_req(1, 1'b0, 2, 1'b0);
    run_req(0, 1'b0, 0, 1'b0);
    run_req(3, 1'b1, 0, 1'b1);
    run_req(15, 1'b0, 1, 1'b0);

    // abort a reps=3 request during SEND2
    push_req(3, 1'b0);
    bus.start = 1'b1;
    bus.reps = CNT_W'(3);
    bus.gap = 1'b0;
    bus.ready = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("abort_in_send2", {bus.valid, bus.num}, 3'b110);
    reset = 1'b1;
    #1;
    chk("abort_outputs",
        {bus.num, bus.valid, bus.busy, bus.done}, 5'b00000);
    sb.delete();
    step();
    chk("abort_held",
        {bus.num, bus.valid, bus.busy, bus.done}, 5'b00000);
    reset = 1'b0;
    step();
    chk("abort_no_done", {bus.busy, bus.done}, 2'b00);
    run_req(1, 1'b0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_req($urandom_range(0, 15), 1'($urandom), $urandom_range(0, 1),
              1'($urandom));
    end

    step();
    step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counting_sender.md
# counting_sender

Transmit-side counterpart of the `1,2,3` pattern detector: on a start request it drives the 2-bit symbol stream `num` with a programmed number of `1,2,3` patterns, optionally separated by idle symbols. It sits in front of the detector in the counting test subsystem and drives stimulus and loopback traffic into the detector's `num` input. Downstream back-pressure is supported via `ready`.

## Interface
- `CNT_W`, default 4: width of the repetition count; up to 2^CNT_W−1 patterns per request.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  request pulse; sampled only in IDLE.
- `reps`  in  CNT_W  number of patterns; latched when `start` is accepted.
- `gap`  in  1  1 = insert one idle symbol (`num`=0) between consecutive patterns; latched with `reps`.
- `ready`  in  1  downstream accepts the current symbol this cycle.
- `num`  out  2  current symbol; 0 when not sending.
- `valid`  out  1  `num` carries a pattern symbol (1, 2 or 3).
- `busy`  out  1  a request is in progress: high from the cycle after accept through the `done` cycle.
- `done`  out  1  one-cycle pulse on request completion.

## Operation
- States: IDLE, SEND1, SEND2, SEND3, GAP, FIN.
- Outputs are decoded from registered state only: `num`=1/2/3 in SEND1/2/3, else 0. `valid`=1 only in SEND1/2/3. `busy`=1 in every state except IDLE. `done`=1 only in FIN.
- IDLE:
  - If `start`=1 and `reps`≠0: latch `reps` into the remaining counter and latch `gap`, then go to SEND1.
  - If `start`=1 and `reps`=0: go to FIN. No symbols are sent.
- SENDk (k=1,2): if `ready`=1, advance to SEND(k+1). Otherwise hold; `num` and `valid` stay stable.
- SEND3, when `ready`=1:
  - Decrement the remaining counter.
  - If the count after decrement is 0, go to FIN.
  - Otherwise go to GAP if latched `gap`=1, else to SEND1.
- SEND3 with `ready`=0: hold.
- GAP: always lasts exactly one cycle, independent of `ready`; then SEND1.
- FIN: lasts one cycle, then IDLE.
- `start` outside IDLE is ignored. It is not queued.
- Changes to `reps` and `gap` after accept have no effect on the request in progress.
- Counter arithmetic is unsigned CNT_W bits. It never underflows because 0 is intercepted at accept.

## Timing
- Reset values: state IDLE, counter 0, latched gap 0. Resulting outputs: `num`=0, `valid`=0, `busy`=0, `done`=0.
- Reset asserted mid-request aborts it in the same cycle. No `done` is generated.
- Latency: `start` accepted at edge t, first symbol (`num`=1) visible after edge t.
- With `ready` held high, the request takes 3·reps + (gap ? reps−1 : 0) cycles of SENDx/GAP, then one FIN cycle.
- `done` is high in the cycle after the last `num`=3 is accepted.
- A new `start` can be accepted in the cycle after FIN, i.e. while back in IDLE.
- `start` asserted in the same cycle as FIN is ignored.

## Structure
- Shared package/header holds:
  - Symbol constants `SYM_IDLE`=0, `SYM_1`=1, `SYM_2`=2, `SYM_3`=3. The detector uses the same constants.
  - Sender state encodings (3 bits).
- Single module; no sub-module needed.
- Remaining-pattern counter and FSM live in the same module.

## Test plan
- Reset, then `start` with `reps`=2, `gap`=0, `ready`=1 → `num` = 1,2,3,1,2,3 on 6 consecutive cycles, then `done`=1 for one cycle, then `busy`=0.
- `reps`=2, `gap`=1 → `num` = 1,2,3,0,1,2,3 with `valid`=0 on the 0 cycle, then `done` pulse. Output fed into the detector: its `ans`=1 after each 3.
- `reps`=1 with `ready` low for 2 cycles during SEND2 → `num`=2 held for 3 cycles with `valid`=1, then 3, then `done`.
- `start` with `reps`=0 → no `valid` cycles; `busy`=1 and `done`=1 in the single cycle after accept.
- `start` pulsed again mid-request (and in the FIN cycle) → ignored; the total symbol count matches the first request only.
- `reset` asserted during SEND2 of a `reps`=3 request → `num`, `valid`, `busy` and `done` go to 0 immediately with no `done` pulse; a subsequent `start` with `reps`=1 sends 1,2,3 normally.
